// File: rtl/demux2_4_stream_pkg.sv
// -----------------------------------------------------------------------------
// demux2_4_stream_pkg
//   Shared definitions for the registered 1-to-2 stream demultiplexer.
//   CH_A / CH_B  : destination channel encodings (0 = A, 1 = B)
//   WIDTH_DEF    : default data width
//   DEPTH_DEF    : default per-output FIFO depth
//   sel_dst()    : destination of the current beat (auto toggle or explicit s)
// -----------------------------------------------------------------------------
package demux2_4_stream_pkg;

   localparam logic CH_A = 1'b0;
   localparam logic CH_B = 1'b1;

   localparam int WIDTH_DEF = 4;
   localparam int DEPTH_DEF = 2;

   function automatic logic sel_dst(input logic mode, input logic toggle, input logic s);
      return mode ? toggle : s;
   endfunction

endpackage

// File: rtl/demux2_4_stream_fifo.sv
// -----------------------------------------------------------------------------
// demux_fifo
//   Small synchronous FIFO used for each output of demux2_4_stream.
//   Ports:
//     clk    in   rising-edge clock
//     rst_n  in   asynchronous active-low reset (empties the FIFO)
//     push   in   write din at the tail (ignored while full)
//     din    in   WIDTH data to write
//     full   out  count == DEPTH
//     pop    in   remove the head (ignored while empty)
//     dout   out  head entry, or 0 while empty
//     empty  out  count == 0
// -----------------------------------------------------------------------------
module demux_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST     = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   // Pointers wrap at DEPTH-1 so non-power-of-two depths work too.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   assign full    = (count_q == FULL_CNT);
   assign empty   = (count_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // An empty FIFO shows 0 rather than stale storage.
   assign dout = empty ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; validity is tracked by count_q alone.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/demux2_4_stream.sv
// -----------------------------------------------------------------------------
// demux2_4_stream
//   Registered 1-to-2 stream demultiplexer. Each input beat is routed to
//   output A or B, chosen by s (mode = 0) or by an alternating toggle
//   (mode = 1). Each output is buffered by its own FIFO so a stalled consumer
//   never drops data or blocks the other output.
//   Ports:
//     clk, reset            clock, asynchronous active-low reset
//     In, in_valid/in_ready input stream
//     s, mode               destination select / auto-alternate enable
//     A, a_valid/a_ready    output stream A (head of FIFO A)
//     B, b_valid/b_ready    output stream B (head of FIFO B)
//     toggle                next auto-mode destination (0 = A, 1 = B)
// -----------------------------------------------------------------------------
module demux2_4_stream
   import demux2_4_stream_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] In,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             s,
   input  logic             mode,
   output logic [WIDTH-1:0] A,
   output logic             a_valid,
   input  logic             a_ready,
   output logic [WIDTH-1:0] B,
   output logic             b_valid,
   input  logic             b_ready,
   output logic             toggle
);

   logic dst;
   logic accept;
   logic push_a, push_b;
   logic full_a, full_b;
   logic empty_a, empty_b;
   logic toggle_q, toggle_d;

   assign dst = sel_dst(mode, toggle_q, s);

   // Readiness comes only from registered occupancy of the selected FIFO;
   // a pop in the same cycle does not free a slot for this beat.
   assign in_ready = (dst == CH_A) ? ~full_a : ~full_b;
   assign accept   = in_valid & in_ready;
   assign push_a   = accept & (dst == CH_A);
   assign push_b   = accept & (dst == CH_B);

   // Only accepted auto-mode beats advance the alternation.
   assign toggle_d = toggle_q ^ (accept & mode);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) toggle_q <= 1'b0;
      else        toggle_q <= toggle_d;
   end

   assign toggle  = toggle_q;
   assign a_valid = ~empty_a;
   assign b_valid = ~empty_b;

   demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) fifo_a (
      .clk   (clk),
      .rst_n (reset),
      .push  (push_a),
      .din   (In),
      .full  (full_a),
      .pop   (a_ready),
      .dout  (A),
      .empty (empty_a)
   );

   demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) fifo_b (
      .clk   (clk),
      .rst_n (reset),
      .push  (push_b),
      .din   (In),
      .full  (full_b),
      .pop   (b_ready),
      .dout  (B),
      .empty (empty_b)
   );

endmodule
